// File: rtl/snd_pkg.sv
// Shared FSM state encodings and COMMAND codes for the sound VRAM reader.
package snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ADDR = 2'b10,
    ST_DATA = 2'b11
  } state_t;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;

endpackage

// File: rtl/snd_burst_calc.sv
// Next-burst sizing: beats = min(BURST_LEN, remaining bytes / BEAT_BYTES).
module snd_burst_calc #(
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 4,
  parameter int BURST_LEN  = 64
) (
  input  logic [ADDR_W-1:0] i_size,
  input  logic [ADDR_W-1:0] i_offset,
  output logic [8:0]        o_len,
  output logic [7:0]        o_arlen,
  output logic [ADDR_W-1:0] o_bytes,
  output logic              o_last
);

  localparam int SH = $clog2(BEAT_BYTES);

  logic [ADDR_W-1:0] w_rem;
  logic [ADDR_W-1:0] w_rem_beats;

  assign w_rem       = i_size - i_offset;
  assign w_rem_beats = w_rem >> SH;
  assign o_len       = (w_rem_beats >= ADDR_W'(BURST_LEN)) ? 9'(BURST_LEN) : 9'(w_rem_beats);
  assign o_arlen     = 8'(o_len - 9'd1);
  assign o_bytes     = ADDR_W'(o_len) << SH;
  // This burst consumes everything that is left of the sound.
  assign o_last      = (o_bytes == w_rem);

endmodule

// File: rtl/snd_vramrd.sv
// AXI read master streaming a sound buffer from VRAM into a downstream FIFO,
// one burst outstanding, issuing a burst only when FIFO space is reserved.
import snd_pkg::*;

module snd_vramrd #(
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 4,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = 11
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic              RVALID,
  input  logic              RLAST,
  input  logic [1:0]        RRESP,
  output logic              RREADY,
  input  logic [ADDR_W-1:0] SNDADDR,
  input  logic [ADDR_W-1:0] SNDSIZE,
  input  logic              LOOP,
  input  logic [1:0]        COMMAND,
  input  logic [CNT_W-1:0]  FIFOCNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BEAT_BYTES - 1));

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_size;
  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic              r_loop;
  logic              r_stop;
  logic              r_err;
  logic              r_done;

  logic [8:0]        w_len;
  logic [7:0]        w_arlen;
  logic [ADDR_W-1:0] w_bytes;
  logic              w_last;
  logic [ADDR_W-1:0] w_size_al;
  logic              w_start;
  logic              w_stop_cmd;
  logic              w_space_ok;
  logic              w_last_beat;
  logic              w_bad_beat;
  logic              w_abort;

  snd_burst_calc #(
    .ADDR_W     (ADDR_W),
    .BEAT_BYTES (BEAT_BYTES),
    .BURST_LEN  (BURST_LEN)
  ) u_calc (
    .i_size   (r_size),
    .i_offset (r_offset),
    .o_len    (w_len),
    .o_arlen  (w_arlen),
    .o_bytes  (w_bytes),
    .o_last   (w_last)
  );

  assign w_size_al   = SNDSIZE & ALIGN_MASK;
  assign w_start     = (COMMAND == CMD_START) && (w_size_al != '0);
  assign w_stop_cmd  = (COMMAND == CMD_STOP);
  assign w_space_ok  = (32'(FIFOCNT) + 32'(w_len)) <= 32'(FIFO_DEPTH);
  assign w_last_beat = (r_state == ST_DATA) && RVALID && RLAST;
  assign w_bad_beat  = (r_state == ST_DATA) && RVALID && (RRESP != 2'b00);
  // Any stop request or bad response ends the run once the burst has drained.
  assign w_abort     = r_stop || w_stop_cmd || r_err || w_bad_beat;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ARVALID      = 1'b0;
    RREADY       = 1'b0;
    BUSY         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (w_start) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_stop_cmd)      w_state_next = ST_IDLE;
        else if (w_space_ok) w_state_next = ST_ADDR;
      end
      ST_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        RREADY = 1'b1;
        if (w_last_beat) begin
          if (w_abort || (w_last && !r_loop)) w_state_next = ST_IDLE;
          else                                 w_state_next = ST_WAIT;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_base   <= '0;
      r_size   <= '0;
      r_offset <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_loop   <= 1'b0;
      r_stop   <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_base   <= SNDADDR & ALIGN_MASK;
            r_size   <= w_size_al;
            r_loop   <= LOOP;
            r_offset <= '0;
            r_stop   <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!w_stop_cmd && w_space_ok) begin
            r_araddr <= r_base + r_offset;
            r_arlen  <= w_arlen;
          end
        end
        ST_ADDR: begin
          if (w_stop_cmd) r_stop <= 1'b1;
        end
        ST_DATA: begin
          if (w_bad_beat) r_err <= 1'b1;
          if (w_last_beat) begin
            r_stop   <= 1'b0;
            r_offset <= w_last ? '0 : r_offset + w_bytes;
            if (w_last && !r_loop && !w_abort) r_done <= 1'b1;
          end else if (w_stop_cmd) begin
            r_stop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ARADDR = r_araddr;
  assign ARLEN  = r_arlen;
  assign DONE   = r_done;
  assign ERR    = r_err;

endmodule

// File: tb/tb_snd_vramrd.sv
// Self-checking bench for snd_vramrd: directed scenarios plus randomized sounds
// checked against a burst plan computed from byte size and burst limits.
import snd_pkg::*;

module tb_snd_vramrd;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic        RVALID = 1'b0;
  logic        RLAST = 1'b0;
  logic [1:0]  RRESP = 2'b00;
  logic        RREADY;
  logic [31:0] SNDADDR = '0;
  logic [31:0] SNDSIZE = '0;
  logic        LOOP = 1'b0;
  logic [1:0]  COMMAND = 2'b00;
  logic [10:0] FIFOCNT = '0;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] plan_addr[$];
  logic [7:0]  plan_len[$];

  snd_vramrd #(
    .ADDR_W     (32),
    .BEAT_BYTES (4),
    .BURST_LEN  (64),
    .FIFO_DEPTH (1024),
    .CNT_W      (11)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .ARADDR  (ARADDR),
    .ARLEN   (ARLEN),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RVALID  (RVALID),
    .RLAST   (RLAST),
    .RRESP   (RRESP),
    .RREADY  (RREADY),
    .SNDADDR (SNDADDR),
    .SNDSIZE (SNDSIZE),
    .LOOP    (LOOP),
    .COMMAND (COMMAND),
    .FIFOCNT (FIFOCNT),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sound of N beats = ceil(N/64) bursts; burst k starts k*256 bytes past the base.
  function automatic void build_plan(input logic [31:0] base, input logic [31:0] size_raw);
    int total_beats;
    int beats;
    plan_addr.delete();
    plan_len.delete();
    total_beats = int'((size_raw & ~32'h3) / 4);
    for (int k = 0; k * 64 < total_beats; k++) begin
      beats = total_beats - k * 64;
      if (beats > 64) beats = 64;
      plan_addr.push_back((base & ~32'h3) + 32'(k * 256));
      plan_len.push_back(8'(beats - 1));
    end
  endfunction

  task automatic start_cmd();
    COMMAND = CMD_START;
    tick();
    COMMAND = CMD_NOP;
  endtask

  task automatic do_burst(input string tag, input logic [31:0] eaddr, input logic [7:0] elen,
                          input int bad_beat, input int stop_beat, input bit stop_in_addr);
    int n;
    int gap;
    n = 0;
    while (ARVALID !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_arvalid"}, 64'(ARVALID), 64'd1);
    if (ARVALID !== 1'b1) return;
    $display("burst %s addr=%08h len=%0d", tag, ARADDR, ARLEN);
    check({tag, "_araddr"}, 64'(ARADDR), 64'(eaddr));
    check({tag, "_arlen"}, 64'(ARLEN), 64'(elen));
    if (stop_in_addr) begin
      COMMAND = CMD_STOP;
      tick();
      COMMAND = CMD_NOP;
      check({tag, "_arvalid_hold_stop"}, 64'(ARVALID), 64'd1);
    end
    gap = $urandom_range(0, 3);
    repeat (gap) tick();
    check({tag, "_araddr_stable"}, 64'(ARADDR), 64'(eaddr));
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check({tag, "_arvalid_drop"}, 64'(ARVALID), 64'd0);
    check({tag, "_rready"}, 64'(RREADY), 64'd1);
    for (int b = 0; b <= int'(elen); b++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      RVALID = 1'b1;
      RLAST  = (b == int'(elen));
      RRESP  = (b == bad_beat) ? 2'b10 : 2'b00;
      if (b == stop_beat) COMMAND = CMD_STOP;
      tick();
      RVALID  = 1'b0;
      RLAST   = 1'b0;
      RRESP   = 2'b00;
      COMMAND = CMD_NOP;
      if (b == bad_beat) check({tag, "_err_set"}, 64'(ERR), 64'd1);
      if (b < int'(elen) && (b == stop_beat || b == bad_beat || b == 0))
        check({tag, "_rready_mid"}, 64'(RREADY), 64'd1);
    end
  endtask

  task automatic play(input string tag, input logic [31:0] base, input logic [31:0] size_raw,
                      input int fifo);
    FIFOCNT = 11'(fifo);
    SNDADDR = base;
    SNDSIZE = size_raw;
    LOOP    = 1'b0;
    build_plan(base, size_raw);
    start_cmd();
    check({tag, "_busy_start"}, 64'(BUSY), 64'd1);
    check({tag, "_err_clr"}, 64'(ERR), 64'd0);
    foreach (plan_addr[k]) begin
      do_burst(tag, plan_addr[k], plan_len[k], -1, -1, 1'b0);
      if (k < plan_addr.size() - 1) check({tag, "_no_early_done"}, 64'(DONE), 64'd0);
    end
    check({tag, "_done"}, 64'(DONE), 64'd1);
    check({tag, "_busy_end"}, 64'(BUSY), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    check("rst_arvalid", 64'(ARVALID), 64'd0);
    check("rst_rready", 64'(RREADY), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_araddr", 64'(ARADDR), 64'd0);
    check("rst_arlen", 64'(ARLEN), 64'd0);
    ARESETN = 1'b1;
    tick();

    // Three full bursts, then a short tail burst
    play("three", 32'h1000_0000, 32'h300, 0);
    play("tail", 32'h1000_0000, 32'h140, 0);
    // Address wraps modulo 2^32
    play("wrap", 32'hFFFF_FF00, 32'h200, 100);

    // Start with zero size is ignored
    SNDSIZE = 32'h0;
    start_cmd();
    check("zero_busy", 64'(BUSY), 64'd0);
    tick();
    check("zero_done", 64'(DONE), 64'd0);

    // FIFO space gating, boundary at exactly 64 free entries
    FIFOCNT = 11'd1000;
    SNDADDR = 32'h2000_0000;
    SNDSIZE = 32'h100;
    start_cmd();
    repeat (8) tick();
    check("fifo_full_arvalid", 64'(ARVALID), 64'd0);
    check("fifo_full_busy", 64'(BUSY), 64'd1);
    FIFOCNT = 11'd961;
    repeat (2) tick();
    check("fifo_63_arvalid", 64'(ARVALID), 64'd0);
    FIFOCNT = 11'd960;
    tick();
    check("fifo_64_arvalid", 64'(ARVALID), 64'd1);
    do_burst("fifo", 32'h2000_0000, 8'd63, -1, -1, 1'b0);
    check("fifo_done", 64'(DONE), 64'd1);
    tick();

    // Stop while waiting for FIFO space
    FIFOCNT = 11'd1000;
    start_cmd();
    COMMAND = CMD_STOP;
    tick();
    COMMAND = CMD_NOP;
    check("stopwait_busy", 64'(BUSY), 64'd0);
    check("stopwait_done", 64'(DONE), 64'd0);
    FIFOCNT = 11'd0;
    tick();
    check("stopwait_arvalid", 64'(ARVALID), 64'd0);

    // Looping sound, then stop mid-DATA
    SNDADDR = 32'h3000_0000;
    SNDSIZE = 32'h200;
    LOOP    = 1'b1;
    start_cmd();
    LOOP    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_burst("loop", 32'h3000_0000 + 32'((k % 2) * 256), 8'd63, -1, (k == 3) ? 10 : -1, 1'b0);
      check("loop_done", 64'(DONE), 64'd0);
      check("loop_busy", 64'(BUSY), (k == 3) ? 64'd0 : 64'd1);
    end
    tick();
    check("loop_stop_done", 64'(DONE), 64'd0);

    // Stop while the address is offered
    SNDADDR = 32'h5000_0000;
    SNDSIZE = 32'h300;
    start_cmd();
    do_burst("stopaddr", 32'h5000_0000, 8'd63, -1, -1, 1'b1);
    check("stopaddr_busy", 64'(BUSY), 64'd0);
    check("stopaddr_done", 64'(DONE), 64'd0);

    // Error response on beat 5
    SNDADDR = 32'h4000_0000;
    SNDSIZE = 32'h200;
    start_cmd();
    do_burst("err", 32'h4000_0000, 8'd63, 5, -1, 1'b0);
    check("err_busy", 64'(BUSY), 64'd0);
    check("err_done", 64'(DONE), 64'd0);
    check("err_sticky", 64'(ERR), 64'd1);
    tick();
    check("err_no_more", 64'(ARVALID), 64'd0);
    check("err_hold", 64'(ERR), 64'd1);

    // Randomized sounds (misaligned low size bits ignored)
    for (int r = 0; r < 6; r++) begin
      play("rand", $urandom & 32'hFFFF_FF00,
           (32'($urandom_range(1, 384)) * 4) | 32'($urandom_range(0, 3)),
           int'($urandom_range(0, 960)));
    end

    // Reset in the middle of a burst
    SNDADDR = 32'h6000_0000;
    SNDSIZE = 32'h100;
    start_cmd();
    n = 0;
    while (ARVALID !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("mid_arvalid", 64'(ARVALID), 64'd1);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    RVALID  = 1'b1;
    repeat (3) tick();
    ARESETN = 1'b0;
    RVALID  = 1'b0;
    tick();
    check("midrst_arvalid", 64'(ARVALID), 64'd0);
    check("midrst_rready", 64'(RREADY), 64'd0);
    check("midrst_busy", 64'(BUSY), 64'd0);
    check("midrst_done", 64'(DONE), 64'd0);
    check("midrst_err", 64'(ERR), 64'd0);
    check("midrst_araddr", 64'(ARADDR), 64'd0);
    check("midrst_arlen", 64'(ARLEN), 64'd0);
    ARESETN = 1'b1;
    tick();
    check("post_rst_busy", 64'(BUSY), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/snd_vramrd.md
SND_VRAMRD -- requirements
Module: snd_vramrd

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI address width.
REQ-002 SHALL have parameter BEAT_BYTES, default 4: bytes per R beat, power of two.
REQ-003 SHALL have parameter BURST_LEN, default 64: maximum beats per burst, 1..256.
REQ-004 SHALL have parameter FIFO_DEPTH, default 1024: downstream FIFO depth in beats.
REQ-005 SHALL have parameter CNT_W, default 11: width of FIFOCNT, at least clog2(FIFO_DEPTH)+1.
REQ-006 SHALL have port ACLK, input, 1 bit: sole clock.
REQ-007 SHALL have port ARESETN, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port ARADDR, output, ADDR_W bits: burst start address.
REQ-009 SHALL have ports ARLEN (output, 8 bits: beats-1), ARVALID (output, 1 bit) and ARREADY (input, 1 bit).
REQ-010 SHALL have ports RVALID (input, 1), RLAST (input, 1), RRESP (input, 2) and RREADY (output, 1).
REQ-011 SHALL have ports SNDADDR (input, ADDR_W), SNDSIZE (input, ADDR_W, bytes), LOOP (input, 1) and COMMAND (input, 2: 00 nop, 01 start, 10 stop, 11 reserved/nop).
REQ-012 SHALL have port FIFOCNT, input, CNT_W bits: current downstream FIFO occupancy.
REQ-013 SHALL have ports BUSY (output, 1), DONE (output, 1-cycle pulse) and ERR (output, 1, sticky).

Function
REQ-014 SHALL use states IDLE, WAIT, ADDR, DATA.
- IDLE->WAIT: COMMAND=01 and SNDSIZE!=0; latches SNDADDR, SNDSIZE, LOOP; offset=0.
- COMMAND=01 with SNDSIZE=0: stay IDLE, no DONE.
REQ-015 SHALL compute next length len=min(BURST_LEN, (SNDSIZE-offset)/BEAT_BYTES) and drive ARLEN=len-1; SNDSIZE and SNDADDR are BEAT_BYTES-aligned (misaligned low bits ignored).
REQ-016 SHALL leave WAIT for ADDR only when FIFO_DEPTH-FIFOCNT>=len, evaluated every cycle.
REQ-017 SHALL hold ARVALID=1 exactly while in ADDR, with ARADDR=latched base+offset and ARLEN stable; on ARREADY go to DATA.
REQ-018 SHALL hold RREADY=1 exactly while in DATA (space is pre-reserved; at most one burst outstanding).
REQ-019 SHALL, on the RVALID&RLAST handshake, advance offset by len*BEAT_BYTES and then:
- offset reached SNDSIZE, LOOP=1: offset=0, go to WAIT.
- offset reached SNDSIZE, LOOP=0: pulse DONE next cycle, go to IDLE.
- otherwise: go to WAIT.
REQ-020 SHALL set ERR if RRESP!=00 on any accepted beat; the burst completes normally, then the block goes IDLE without DONE.
REQ-021 SHALL treat COMMAND=10 as follows:
- In IDLE or WAIT: go to IDLE next cycle.
- In ADDR or DATA: set a stop-pending flag, complete the address handshake and every remaining beat, then go IDLE without DONE.
- ARVALID never drops before ARREADY.
REQ-022 SHALL ignore COMMAND=01 while BUSY; COMMAND=10 and 01 are never simultaneous (single field).
REQ-023 SHALL drive BUSY=1 in every state except IDLE.
REQ-024 SHALL compute the offset at ADDR_W bits; base+offset wraps modulo 2^ADDR_W, with no 4 KB boundary splitting (BURST_LEN*BEAT_BYTES<=4096 and base aligned to it).
REQ-025 SHALL clear ERR on an accepted COMMAND=01.

Reset
REQ-026 SHALL, with ARESETN=0 at a rising ACLK edge, force: state IDLE; ARVALID, RREADY, BUSY, DONE, ERR at 0; offset 0; stop-pending 0.
REQ-027 SHALL allow reset mid-burst to abandon the transaction (the interconnect is reset with the block); ARADDR and ARLEN reset to 0.

Structure
REQ-028 SHALL place state encodings and COMMAND codes (CMD_NOP, CMD_START, CMD_STOP) in shared package snd_pkg.
REQ-029 SHALL implement the len/ARLEN/remaining-size calculation in one sub-module, snd_burst_calc (combinational, parameterised by BEAT_BYTES and BURST_LEN).

Verification
Defaults BEAT_BYTES=4, BURST_LEN=64, FIFO_DEPTH=1024.
REQ-030 SHALL cover: SNDADDR=0x1000_0000, SNDSIZE=0x300, LOOP=0, FIFOCNT=0 -> ARADDR 0x1000_0000, 0x1000_0100, 0x1000_0200, each ARLEN=63, then one DONE pulse and BUSY=0.
REQ-031 SHALL cover: SNDSIZE=0x140 -> bursts ARLEN=63 at +0x000 and ARLEN=15 at +0x100, then DONE.
REQ-032 SHALL cover: LOOP=1, SNDSIZE=0x200 -> ARADDR sequence +0x000, +0x100, +0x000, +0x100..., no DONE; COMMAND=10 during DATA -> remaining beats accepted, then IDLE with no DONE.
REQ-033 SHALL cover: FIFOCNT=1000 held -> ARVALID stays 0; FIFOCNT dropped to 960 -> ARVALID asserts the next cycle.
REQ-034 SHALL cover: RRESP=10 on beat 5 -> ERR=1, burst drains, IDLE without DONE; ARESETN=0 mid-DATA -> all outputs 0 the next cycle.
